pe_feeder: RTL

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/tpu_pkg.sv | 19 +
 rtl/pe_feeder_if.sv | 34 +++
 rtl/pair_fifo.sv | 60 ++++++
 rtl/pe_feeder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath widths and the feeder FSM state encoding.
package tpu_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PSUM_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_SETTLE = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_e;

    function automatic logic state_is_busy(input feeder_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// Bundle of job, FIFO-push and PE-facing signals between a controller and pe_feeder.
interface pe_feeder_if import tpu_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int LEN_W      = 4
);
    logic                  start_i;
    logic [DATA_WIDTH-1:0] weight_data_i;
    logic [LEN_W-1:0]      vec_len_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_ifmap_i;
    logic [PSUM_WIDTH-1:0] wr_psum_i;
    logic                  full_o;
    logic [DATA_WIDTH-1:0] weight_o;
    logic                  weight_en_o;
    logic [DATA_WIDTH-1:0] ifmap_o;
    logic                  ifmap_en_o;
    logic [PSUM_WIDTH-1:0] psum_o;
    logic                  psum_en_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i, weight_data_i, vec_len_i, wr_en_i, wr_ifmap_i, wr_psum_i,
        input  full_o, weight_o, weight_en_o, ifmap_o, ifmap_en_o,
               psum_o, psum_en_o, busy_o, done_o
    );

    modport slave (
        input  start_i, weight_data_i, vec_len_i, wr_en_i, wr_ifmap_i, wr_psum_i,
        output full_o, weight_o, weight_en_o, ifmap_o, ifmap_en_o,
               psum_o, psum_en_o, busy_o, done_o
    );
endinterface

// File: rtl/pair_fifo.sv
// Synchronous FIFO of ifmap/psum pairs; head entry is visible combinationally on pop_data_o.
module pair_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_push    = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/pe_feeder.sv
// Loads a weight into a PE, waits a settle gap, then streams queued ifmap/psum pairs with registered enables.
module pe_feeder import tpu_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_feeder_if.slave    bus
);
    localparam int LEN_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int PAIR_W = DATA_WIDTH + PSUM_WIDTH;

    feeder_state_e         state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DATA_WIDTH-1:0] weight_q, weight_d;
    logic                  weight_en_q, weight_en_d;
    logic [DATA_WIDTH-1:0] ifmap_q, ifmap_d;
    logic [PSUM_WIDTH-1:0] psum_q, psum_d;
    logic                  pair_en_q, pair_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [PAIR_W-1:0]     fifo_head;
    logic                  fifo_empty;
    logic                  fifo_pop;

    pair_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bus.wr_en_i),
        .push_data_i ({bus.wr_ifmap_i, bus.wr_psum_i}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (bus.full_o),
        .empty_o     (fifo_empty)
    );

    assign fifo_pop = (state_q == ST_STREAM) && !fifo_empty && (len_q != '0);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        gap_d       = gap_q;
        weight_d    = weight_q;
        weight_en_d = 1'b0;
        ifmap_d     = ifmap_q;
        psum_d      = psum_q;
        pair_en_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d     = ST_LOAD_W;
                    weight_d    = bus.weight_data_i;
                    len_d       = bus.vec_len_i;
                    weight_en_d = 1'b1;
                end
            end
            ST_LOAD_W: begin
                state_d = ST_SETTLE;
                gap_d   = GAP_W'(GAP_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (gap_q == '0) begin
                    state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_STREAM: begin
                // Leaving only once remaining hits zero puts done one cycle after the last pair enable.
                if (len_q == '0) begin
                    state_d = ST_DONE;
                end else if (fifo_pop) begin
                    {ifmap_d, psum_d} = fifo_head;
                    pair_en_d         = 1'b1;
                    len_d             = len_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            gap_q       <= '0;
            weight_q    <= '0;
            weight_en_q <= 1'b0;
            ifmap_q     <= '0;
            psum_q      <= '0;
            pair_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            weight_q    <= weight_d;
            weight_en_q <= weight_en_d;
            ifmap_q     <= ifmap_d;
            psum_q      <= psum_d;
            pair_en_q   <= pair_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.weight_o    = weight_q;
    assign bus.weight_en_o = weight_en_q;
    assign bus.ifmap_o     = ifmap_q;
    assign bus.ifmap_en_o  = pair_en_q;
    assign bus.psum_o      = psum_q;
    assign bus.psum_en_o   = pair_en_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

endmodule
